// File: rtl/movegen_board_scanner_if.sv
// ============================================================================
// Module      : movegen_board_scanner_if
// Description : Board-RAM read port and piece-stack write port of the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface movegen_board_scanner_if #(
    parameter int WIDTH = 10
);
    logic             board_rd;
    logic [5:0]       board_addr;
    logic [3:0]       board_data;
    logic             stack_clear;
    logic             stack_load;
    logic [WIDTH-1:0] stack_data;

    modport master (
        output board_rd,
        output board_addr,
        input  board_data,
        output stack_clear,
        output stack_load,
        output stack_data
    );

    modport slave (
        input  board_rd,
        input  board_addr,
        output board_data,
        input  stack_clear,
        input  stack_load,
        input  stack_data
    );
endinterface

`default_nettype wire

// File: rtl/movegen_board_scanner.sv
// ============================================================================
// Module      : movegen_board_scanner
// Description : Scans 64 board squares and pushes side-to-move pieces as
//               {square, piece} words onto the move-generator piece stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module movegen_board_scanner #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic             side,
    movegen_board_scanner_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SCAN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    localparam logic [5:0]       c_LAST_SQ = 6'd63;
    localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic             r_side;
    logic [5:0]       r_addr;
    logic             r_drain;
    logic             r_rd_v;
    logic [5:0]       r_rd_addr;
    logic             r_load;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic             w_board_rd;
    logic             w_stack_clear;
    logic             w_busy;
    logic             w_done;
    logic             w_start_acc;
    logic             w_match;
    logic             w_room;

    assign w_start_acc = (r_state == c_ST_IDLE) && start;

    // Type 0 is empty regardless of the colour bit.
    assign w_match = r_rd_v && (bus.board_data[2:0] != 3'd0) &&
                     (bus.board_data[3] == r_side);
    assign w_room  = (r_count < c_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = c_ST_SCAN;
                end
            end
            c_ST_SCAN: begin
                if (r_addr == c_LAST_SQ) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_drain) begin
                    w_next_state = c_ST_FINISH;
                end
            end
            c_ST_FINISH: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_board_rd    = 1'b0;
        w_stack_clear = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            c_ST_SCAN: begin
                w_board_rd    = 1'b1;
                w_stack_clear = (r_addr == 6'd0);
                w_busy        = 1'b1;
            end
            c_ST_DRAIN: begin
                w_busy = 1'b1;
            end
            c_ST_FINISH: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Read pipeline and push logic; square n's data is qualified in the
    // cycle after its read strobe, and its push is registered one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_side    <= 1'b0;
            r_addr    <= 6'd0;
            r_drain   <= 1'b0;
            r_rd_v    <= 1'b0;
            r_rd_addr <= 6'd0;
            r_load    <= 1'b0;
            r_data    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_rd_v    <= w_board_rd;
            r_rd_addr <= r_addr;
            r_drain   <= (r_state == c_ST_DRAIN);
            r_load    <= w_match && w_room;

            if (r_state == c_ST_SCAN) begin
                r_addr <= r_addr + 6'd1;
            end

            if (w_match && w_room) begin
                r_data  <= {r_rd_addr, bus.board_data};
                r_count <= r_count + CNT_W'(1);
            end
            if (w_match && !w_room) begin
                r_ovf <= 1'b1;
            end

            if (w_start_acc) begin
                r_side  <= side;
                r_addr  <= 6'd0;
                r_drain <= 1'b0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign bus.board_rd    = w_board_rd;
    assign bus.board_addr  = w_board_rd ? r_addr : 6'd0;
    assign bus.stack_clear = w_stack_clear;
    assign bus.stack_load  = r_load;
    assign bus.stack_data  = r_data;
    assign busy            = w_busy;
    assign done            = w_done;
    assign count           = r_count;
    assign overflow        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_movegen_board_scanner.sv
// ============================================================================
// Module      : tb_movegen_board_scanner
// Description : Scoreboard bench with board-RAM model and reference scan model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_movegen_board_scanner;

    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             side = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    movegen_board_scanner_if #(.WIDTH(WIDTH)) bus ();

    movegen_board_scanner #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .side     (side),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    logic [3:0] board [64];

    always @(posedge clk) begin
        if (bus.board_rd) bus.board_data <= board[bus.board_addr];
    end

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   s_cyc = 0;
    int   exp_cnt = 0;
    int   exp_ovf = 0;
    int   exp_ovf_cyc = -1;
    int   done_cnt = 0;
    int   clear_cnt = 0;
    logic prev_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compares each DUT event against the front of the scoreboard.
    always @(negedge clk) begin
        int rel;
        exp_t e;
        rel = cyc - s_cyc;
        if (!reset) begin
            if (bus.stack_clear && bus.stack_load) chk("clear_and_load", 1, 0);
            if (bus.stack_clear) begin
                clear_cnt++;
                chk("clear_cycle", rel, 1);
            end
            if (bus.stack_load) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", int'(bus.stack_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_data", int'(bus.stack_data), e.data);
                    chk("load_cycle", rel, e.cyc);
                end
            end
            if (overflow && !prev_ovf) chk("ovf_rise_cycle", rel, exp_ovf_cyc);
            if (done) begin
                done_cnt++;
                chk("done_cycle", rel, 67);
                chk("done_count", int'(count), exp_cnt);
                chk("done_overflow", int'(overflow), exp_ovf);
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_busy", int'(busy), 0);
            end
        end
        prev_ovf = overflow;
    end

    // Reference: every non-empty piece of the side to move, in square order,
    // until the stack is full; the first surplus piece marks overflow.
    task automatic build_expect(input logic s);
        exp_t e;
        exp_cnt = 0;
        exp_ovf = 0;
        exp_ovf_cyc = -1;
        for (int sq = 0; sq < 64; sq++) begin
            if (board[sq][2:0] != 3'd0 && board[sq][3] == s) begin
                if (exp_cnt < DEPTH) begin
                    e.data = sq * 16 + int'(board[sq]);
                    e.cyc  = sq + 3;
                    exp_q.push_back(e);
                    exp_cnt++;
                end else if (exp_ovf == 0) begin
                    exp_ovf = 1;
                    exp_ovf_cyc = sq + 3;
                end
            end
        end
    endtask

    task automatic issue_start(input logic s);
        @(negedge clk);
        start = 1'b1;
        side  = s;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        side  = ~s;
    endtask

    task automatic run_scan(input logic s, input string tag);
        int d0, c0;
        bit seen;
        d0 = done_cnt;
        c0 = clear_cnt;
        build_expect(s);
        issue_start(s);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > d0) seen = 1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_one_clear"}, clear_cnt - c0, 1);
        exp_q.delete();
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
    endtask

    task automatic init_position();
        int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        clear_board();
        for (int f = 0; f < 8; f++) begin
            board[f]      = 4'(back[f]);
            board[8 + f]  = 4'd1;
            board[48 + f] = 4'd9;
            board[56 + f] = 4'(8 + back[f]);
        end
    endtask

    task automatic abort_test();
        int d0;
        logic [WIDTH+6+CNT_W+6-1:0] outs;
        init_position();
        d0 = done_cnt;
        build_expect(1'b1);
        issue_start(1'b1);
        for (int c = 2; c <= 31; c++) begin
            @(negedge clk);
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            if (c == 30) reset = 1'b1;
            if (c == 31) begin
                outs = {bus.board_rd, bus.board_addr, bus.stack_clear, bus.stack_load,
                        bus.stack_data, busy, done, count, overflow};
                chk("abort_outputs_zero", int'(outs), 0);
                reset = 1'b0;
            end
        end
        exp_q.delete();
        repeat (80) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle_busy", int'(busy), 0);
    endtask

    initial begin
        int dens;
        clear_board();
        bus.board_data = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", int'({bus.board_rd, bus.stack_clear, bus.stack_load, busy,
                                  done, overflow}), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_data", int'(bus.stack_data), 0);
        reset = 1'b0;
        @(negedge clk);

        clear_board();
        run_scan(1'b0, "empty");

        init_position();
        run_scan(1'b0, "init_white");
        init_position();
        run_scan(1'b1, "init_black");

        clear_board();
        for (int sq = 8; sq <= 24; sq++) board[sq] = 4'd1;
        run_scan(1'b0, "pawns17");

        clear_board();
        board[63] = 4'hE;
        board[0]  = 4'h6;
        board[5]  = 4'h8;
        run_scan(1'b1, "king_h8");

        for (int r = 0; r < 8; r++) begin
            dens = $urandom_range(10, 80);
            for (int sq = 0; sq < 64; sq++)
                board[sq] = ($urandom_range(0, 99) < dens) ? 4'($urandom_range(0, 15)) : 4'd0;
            run_scan(1'($urandom_range(0, 1)), "random");
        end

        abort_test();
        init_position();
        run_scan(1'b0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
